store_unit: RTL and testbench

//  Store path of the MIPS data-memory interface: the write-side counterpart of the

---
 rtl/store_unit.sv | 169 ++++++++++++++++
 tb/tb_store_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/store_unit.sv
// store_unit -- store path of the MIPS data-memory interface.
//   Accepts sb/sh/sw requests from MEM, aligns data onto big-endian byte lanes
//   with byte enables, buffers them in a DEPTH-entry FIFO and drains the FIFO
//   to data memory over a req/ack handshake.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned half/word stores are
//   accepted but dropped, flagged on o_misalign_err / o_misalign_addr).
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_st_valid/o_st_ready   store request handshake (ready == !full)
//   i_st_addr/data/size     byte address, rt value, 00=b 01=h 1x=w
//   o_mem_req/addr/wdata/be memory write (word address, lane data, enables)
//   i_mem_ack               memory accepted current write
//   o_busy                  FIFO non-empty or write in flight
//   o_misalign_err/addr     (MISALIGN_TRAP_EN) fault pulse / faulting address
module store_unit #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_st_valid,
  output logic          o_st_ready,
  input  logic [AW-1:0] i_st_addr,
  input  logic [31:0]   i_st_data,
  input  logic [1:0]    i_st_size,
  output logic          o_mem_req,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  output logic [3:0]    o_mem_be,
  input  logic          i_mem_ack,
  output logic          o_busy
`ifdef MISALIGN_TRAP_EN
  ,
  output logic          o_misalign_err,
  output logic [AW-1:0] o_misalign_addr
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-3:0] waddr;
    logic [31:0]   wdata;
    logic [3:0]    be;
  } entry_t;

  typedef enum logic {IDLE, ISSUE} state_t;

  entry_t          r_fifo [DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  state_t          r_state, w_state_nxt;
  entry_t          w_entry, w_head;
  logic            w_accept, w_misalign, w_push, w_pop, w_load;

  // Big-endian lane alignment: be[3] covers bits [31:24], i.e. byte offset 0.
  always_comb begin
    w_entry       = '0;
    w_entry.waddr = i_st_addr[AW-1:2];
    case (i_st_size)
      2'b00: begin
        w_entry.wdata = {4{i_st_data[7:0]}};
        w_entry.be    = 4'b1000 >> i_st_addr[1:0];
      end
      2'b01: begin
        w_entry.wdata = {2{i_st_data[15:0]}};
        w_entry.be    = i_st_addr[1] ? 4'b0011 : 4'b1100;
      end
      default: begin
        w_entry.wdata = i_st_data;
        w_entry.be    = 4'b1111;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = ((i_st_size == 2'b01) && i_st_addr[0]) ||
                      (i_st_size[1] && (i_st_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // Full refuses a push even when the head is popped in the same cycle.
  assign o_st_ready = (r_count != CW'(DEPTH));
  assign w_accept   = i_st_valid && o_st_ready;
  assign w_push     = w_accept && !w_misalign;
  assign w_head     = r_fifo[r_rd_ptr];
  assign o_busy     = (r_count != '0) || (r_state == ISSUE);

  // FSM: the head stays in the FIFO while it is being issued and is popped on ack,
  // so busy covers the in-flight write through the count alone until the ack edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_count != '0) begin
          w_load      = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (i_mem_ack) begin
          w_pop       = 1'b1;
          w_state_nxt = IDLE;   // always pass through IDLE: one dead cycle between writes
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Storage needs no reset; validity is tracked by the pointers/count.
  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_mem_req   <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_be    <= '0;
    end else if (w_load) begin
      o_mem_req   <= 1'b1;
      o_mem_addr  <= {w_head.waddr, 2'b00};
      o_mem_wdata <= w_head.wdata;
      o_mem_be    <= w_head.be;
    end else if (w_pop) begin
      o_mem_req   <= 1'b0;
      o_mem_be    <= '0;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_misalign_err  <= 1'b0;
      o_misalign_addr <= '0;
    end else begin
      o_misalign_err <= w_accept && w_misalign;
      if (w_accept && w_misalign) o_misalign_addr <= i_st_addr;
    end
  end
`endif

endmodule

// File: tb/tb_store_unit.sv
module tb_store_unit;
  localparam int DEPTH = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_st_valid = 1'b0;
  logic        o_st_ready;
  logic [31:0] i_st_addr = '0;
  logic [31:0] i_st_data = '0;
  logic [1:0]  i_st_size = '0;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_ack = 1'b0;
  logic        o_busy;
`ifdef MISALIGN_TRAP_EN
  logic        o_misalign_err;
  logic [31:0] o_misalign_addr;
`endif

  store_unit #(.DEPTH(DEPTH), .AW(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_st_valid(i_st_valid), .o_st_ready(o_st_ready),
    .i_st_addr(i_st_addr), .i_st_data(i_st_data), .i_st_size(i_st_size),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_be(o_mem_be), .i_mem_ack(i_mem_ack), .o_busy(o_busy)
`ifdef MISALIGN_TRAP_EN
    , .o_misalign_err(o_misalign_err), .o_misalign_addr(o_misalign_addr)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  wr_t         q[$];          // writes accepted but not yet acked, in order
  bit          m_req;         // expected mem_req
  logic [31:0] m_mis_addr;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic wr_t align(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    wr_t w;
    int  off;
    off  = int'(a % 4);
    w.a  = a - (a % 4);
    if (sz == 2'd0) begin
      w.be = 4'(1 << (3 - off));
      w.d  = (d % 256) * 32'h0101_0101;
    end else if (sz == 2'd1) begin
      w.be = (off >= 2) ? 4'h3 : 4'hC;
      w.d  = (d % 65536) * 32'h0001_0001;
    end else begin
      w.be = 4'hF;
      w.d  = d;
    end
    return w;
  endfunction

  function automatic bit is_mis(input logic [31:0] a, input logic [1:0] sz);
`ifdef MISALIGN_TRAP_EN
    return (sz == 2'd1 && (a % 2) != 0) || (sz >= 2'd2 && (a % 4) != 0);
`else
    return 1'b0;
`endif
  endfunction

  // One clock: check outputs against the model, drive inputs, advance model.
  task automatic cyc(input bit v, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] sz, input bit ack);
    int occ;
    bit acc, pop, nreq;
    occ = q.size();
    chk("st_ready", o_st_ready, occ < DEPTH);
    chk("busy", o_busy, occ != 0);
    chk("mem_req", o_mem_req, m_req);
    if (m_req) begin
      chk("mem_addr", o_mem_addr, q[0].a);
      chk("mem_wdata", o_mem_wdata, q[0].d);
      chk("mem_be", o_mem_be, q[0].be);
    end else begin
      chk("be_idle", o_mem_be, 4'h0);
    end
    i_st_valid = v; i_st_addr = a; i_st_data = d; i_st_size = sz; i_mem_ack = ack;
    acc  = v && (occ < DEPTH);
    pop  = m_req && ack;
    // a write is presented the cycle after the unit sees an entry while idle,
    // held until acked, then dropped for at least one cycle
    nreq = m_req ? !ack : (occ != 0);
    @(posedge i_clk); #1;
    if (pop) void'(q.pop_front());
    if (acc && !is_mis(a, sz)) q.push_back(align(a, d, sz));
    m_req = nreq;
`ifdef MISALIGN_TRAP_EN
    if (acc && is_mis(a, sz)) m_mis_addr = a;
    chk("mis_err", o_misalign_err, acc && is_mis(a, sz));
    chk("mis_addr", o_misalign_addr, m_mis_addr);
`endif
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0; i_st_valid = 1'b0; i_mem_ack = 1'b0;
    @(posedge i_clk); #1;
    chk("rst_req_1st", o_mem_req, 1'b0);
    @(posedge i_clk); #1;
    chk("rst_req", o_mem_req, 1'b0);
    chk("rst_addr", o_mem_addr, 32'h0);
    chk("rst_wdata", o_mem_wdata, 32'h0);
    chk("rst_be", o_mem_be, 4'h0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_ready", o_st_ready, 1'b1);
`ifdef MISALIGN_TRAP_EN
    chk("rst_mis_err", o_misalign_err, 1'b0);
    chk("rst_mis_addr", o_misalign_addr, 32'h0);
`endif
    i_rst_n = 1'b1;
    q.delete();
    m_req = 1'b0;
    m_mis_addr = '0;
  endtask

  initial begin
    do_reset();

    // byte / half alignment examples
    cyc(1, 32'h1003, 32'hAB, 2'd0, 0);
    chk("sb_no_req_yet", o_mem_req, 1'b0);
    cyc(0, 0, 0, 2'd0, 0);
    chk("sb_addr", o_mem_addr, 32'h1000);
    chk("sb_wdata", o_mem_wdata, 32'hABAB_ABAB);
    chk("sb_be", o_mem_be, 4'b0001);
    cyc(0, 0, 0, 2'd0, 1);
    cyc(1, 32'h2002, 32'h1234, 2'd1, 0);
    cyc(0, 0, 0, 2'd0, 0);
    chk("sh_addr", o_mem_addr, 32'h2000);
    chk("sh_wdata", o_mem_wdata, 32'h1234_1234);
    chk("sh_be", o_mem_be, 4'b0011);
    cyc(0, 0, 0, 2'd0, 1);
    cyc(0, 0, 0, 2'd0, 0);

    // fill with no ack, refuse 5th, then drain in order
    for (int i = 0; i < 4; i++) cyc(1, 32'h100 + 32'(4 * i), $urandom, 2'd2, 0);
    chk("full_ready", o_st_ready, 1'b0);
    cyc(1, 32'h200, 32'h5555_5555, 2'd2, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 2'd0, 1);
    chk("drained_busy", o_busy, 1'b0);

    // push while the head is acked
    cyc(1, 32'h80, 32'h1111_1111, 2'd2, 0);
    cyc(1, 32'h84, 32'h2222_2222, 2'd2, 0);
    chk("pp_req", o_mem_req, 1'b1);
    cyc(1, 32'h40, 32'hDEAD_BEEF, 2'd2, 1);
    chk("pp_count_kept", q.size(), 2);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 2'd0, 1);

    // reset while issuing with two queued; nothing issues afterwards
    cyc(1, 32'h300, 32'hA5A5_A5A5, 2'd2, 0);
    cyc(1, 32'h304, 32'h5A5A_5A5A, 2'd2, 0);
    chk("pre_rst_req", o_mem_req, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 2'd0, 1);

    // misaligned word
    cyc(1, 32'h0006, 32'hCAFE_F00D, 2'd2, 0);
    cyc(0, 0, 0, 2'd0, 0);
`ifdef MISALIGN_TRAP_EN
    chk("mis_not_queued", o_mem_req, 1'b0);
    chk("mis_addr_hold", o_misalign_addr, 32'h0006);
`else
    chk("mw_addr", o_mem_addr, 32'h0004);
    chk("mw_be", o_mem_be, 4'hF);
`endif
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 2'd0, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 699) == 0) do_reset();
      cyc($urandom_range(0, 2) != 0, $urandom, $urandom,
          2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 2'd0, 1);
    chk("final_busy", o_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
